serial_signed_subtracter: RTL and testbench
===========================================

# serial_signed_subtracter

Parametrised, bit-serial two's-complement unit. It either negates A or computes A − B for signed WIDTH-bit operands. One result bit is produced per clock, LSB first, through a single full-adder cell with a registered carry. The result is sign-extended to WIDTH+1 bits, so every outcome is exact, and an overflow flag reports when it does not fit in WIDTH bits. It sits in the arithmetic datapath as the area-cheap, multi-cycle successor to the combinational 4-bit complementer, with a Start/Busy/Done handshake toward the controlling FSM.

## Interface
- WIDTH, 4, operand width in bits (≥2); Result is WIDTH+1 bits
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-low reset (sampled on Clock rising edge, 0 = reset)
- Start  in  1  request; sampled only in IDLE or DONE
- Mode  in  1  0 = negate (Result = −A), 1 = subtract (Result = A − B); captured with Start
- A  in  WIDTH  signed operand, captured on accepted Start
- B  in  WIDTH  signed operand, captured on accepted Start; ignored when Mode=0
- Busy  out  1  high while bits are being computed
- Done  out  1  one-cycle pulse, Result/Overflow valid
- Result  out  WIDTH+1  signed result, held until the next accepted Start
- Overflow  out  1  Result not representable in WIDTH bits (Result[WIDTH] ≠ Result[WIDTH-1]); held with Result

## Operation
- FSM states:
  - IDLE → SHIFT on Start.
  - SHIFT → DONE after WIDTH+1 bit steps.
  - DONE → SHIFT if Start, else → IDLE.
- Accepting Start:
  - Latch X = (Mode ? A : 0) and Y = B when Mode=1, or Y = A when Mode=0.
  - Set carry = 1 (the +1 of two's complement) and bit index i = 0.
- Each SHIFT step:
  - Take x = X[min(i, WIDTH−1)] and y = Y[min(i, WIDTH−1)]. Indexing saturates at WIDTH−1, so step WIDTH uses the sign bits (sign extension).
  - Compute s = x ^ ~y ^ c and c' = majority(x, ~y, c).
  - Shift s into Result from the MSB side, so after WIDTH+1 steps Result[i] holds step i's sum.
- Result is built in an internal shift register. The visible Result and Overflow update only on the SHIFT→DONE transition, so the outputs never show partial values.
- Start during SHIFT is ignored; there is no queueing. Start in DONE is accepted, giving back-to-back operation.
- Mode, A and B are don't-care except on the accepting edge.
- Reset (Reset=0 at an edge), including mid-operation:
  - State → IDLE; Busy=0, Done=0, Result=0, Overflow=0.
  - Carry and index are cleared and the in-flight operation is discarded.
  - Start sampled in the same cycle as Reset=0 is ignored.

## Timing
- Start accepted at edge k. Busy=1 from after edge k through edge k+WIDTH+1.
- Bit i is computed at edge k+1+i. The last bit is at edge k+WIDTH+1, where Result/Overflow load, Busy falls and Done rises.
- Done=1 for exactly the cycle between edges k+WIDTH+1 and k+WIDTH+2.
- Latency: WIDTH+1 cycles from the accepting edge to Done.
- Throughput: one operation per WIDTH+2 cycles with Start held high.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package serial_sub_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the mode constants MODE_NEG=1'b0 and MODE_SUB=1'b1;
  - a function computing the counter width, $clog2(WIDTH+2).
- Sub-module serial_fa_cell: a one-bit full adder with a registered carry. Its ports are Clock, Reset, load (presets carry to 1), en, x, y_inv, sum.
- The top level holds the FSM, operand shift registers, bit counter and result register.

## Test plan
1. Reset with Reset=0 for 2 cycles → Busy=0, Done=0, Result=0, Overflow=0. Then WIDTH=4, Mode=0, A=4'b0011 → Done exactly 5 cycles after the Start edge, Result=5'b11101 (−3), Overflow=0.
2. Negate the corner case: Mode=0, A=4'b1000 (−8) → Result=5'b01000 (+8), Overflow=1. Also A=0 → Result=0, Overflow=0.
3. Subtract: Mode=1 with
   - A=7, B=−8 → Result=5'b01111 (15), Overflow=1;
   - A=−8, B=7 → Result=5'b10001 (−15), Overflow=1;
   - A=5, B=3 → Result=5'b00010, Overflow=0.
4. Handshake: pulse Start again 2 cycles after acceptance with different operands → ignored, first result is unchanged. Start held high in DONE → next operation starts, Done pulses every 6 cycles, Result holds between pulses.
5. Reset mid-operation: drive Reset=0 at step 2 of SHIFT → next cycle IDLE with all outputs 0 and no Done pulse. A fresh Start then yields the correct result.
6. Parameter sweep: WIDTH=2, 8, 16 with random signed A/B and both modes. Compare against the reference A−B or −A at WIDTH+1 bits and against overflow = (result < −2^(WIDTH−1) or result > 2^(WIDTH−1)−1). Check latency = WIDTH+1 every time.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial signed subtracter.
// Holds the FSM state encoding, the mode constants and the bit-counter width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_NEG = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Wide enough to hold the step count for any WIDTH without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder with a registered carry, used as the serial arithmetic core.
// load presets the carry to 1 so that x + ~y + 1 forms x - y.
module serial_fa_cell (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic en,
  input  logic x,
  input  logic y_inv,
  output logic sum
);

  logic carry;

  assign sum = x ^ y_inv ^ carry;

  always_ff @(posedge clock) begin
    if (!reset) begin
      carry <= 1'b0;
    end else if (load) begin
      carry <= 1'b1;
    end else if (en) begin
      carry <= (x & y_inv) | (x & carry) | (y_inv & carry);
    end
  end

endmodule

// File: rtl/serial_signed_subtracter.sv
// Bit-serial two's-complement negate / subtract, one result bit per clock, LSB first.
// Result is WIDTH+1 bits wide and published only when the last bit is computed.
//
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | computing one result bit per clock (WIDTH+1 steps)
//   DONE  | result valid for one cycle; start here chains the next operation
module serial_signed_subtracter
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   result,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nx;
  logic             accept, step, last;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] x_sr, y_sr;
  logic [WIDTH-1:0] acc;
  logic             fa_sum;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    step     = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == '0) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = SHIFT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  serial_fa_cell u_fa (
    .clock (clock),
    .reset (reset),
    .load  (accept),
    .en    (step),
    .x     (x_sr[0]),
    .y_inv (~y_sr[0]),
    .sum   (fa_sum)
  );

  // Arithmetic right shift keeps the sign bit in place, so the last step
  // automatically sees the sign-extended operand bits.
  always_ff @(posedge clock) begin
    if (!reset) begin
      x_sr     <= '0;
      y_sr     <= '0;
      cnt      <= '0;
      acc      <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        x_sr <= (mode == MODE_SUB) ? a : '0;
        y_sr <= (mode == MODE_SUB) ? b : a;
        cnt  <= CW'(WIDTH);
      end else if (step) begin
        x_sr <= {x_sr[WIDTH-1], x_sr[WIDTH-1:1]};
        y_sr <= {y_sr[WIDTH-1], y_sr[WIDTH-1:1]};
        cnt  <= cnt - 1'b1;
        acc  <= {fa_sum, acc[WIDTH-1:1]};
      end
      if (last) begin
        result   <= {fa_sum, acc};
        overflow <= fa_sum ^ acc[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_serial_signed_subtracter.sv
// Self-checking bench: a WIDTH=4 instance for directed/handshake scenarios and
// WIDTH=2/8/16 instances driven together for a randomized sweep.
module tb_serial_signed_subtracter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // WIDTH=4 instance
  logic       rst4, start4, mode4, busy4, done4, ov4;
  logic [3:0] a4, b4;
  logic [4:0] res4;

  serial_signed_subtracter #(.WIDTH(4)) dut4 (
    .clock(clk), .reset(rst4), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(res4), .overflow(ov4)
  );

  // Sweep instances share stimulus; operands are truncated per width.
  logic        rsts, starts, modes;
  logic [15:0] as, bs;
  logic        busy2, done2, ov2, busy8, done8, ov8, busy16, done16, ov16;
  logic [2:0]  res2;
  logic [8:0]  res8;
  logic [16:0] res16;

  serial_signed_subtracter #(.WIDTH(2)) dut2 (
    .clock(clk), .reset(rsts), .start(starts), .mode(modes), .a(as[1:0]), .b(bs[1:0]),
    .busy(busy2), .done(done2), .result(res2), .overflow(ov2)
  );
  serial_signed_subtracter #(.WIDTH(8)) dut8 (
    .clock(clk), .reset(rsts), .start(starts), .mode(modes), .a(as[7:0]), .b(bs[7:0]),
    .busy(busy8), .done(done8), .result(res8), .overflow(ov8)
  );
  serial_signed_subtracter #(.WIDTH(16)) dut16 (
    .clock(clk), .reset(rsts), .start(starts), .mode(modes), .a(as), .b(bs),
    .busy(busy16), .done(done16), .result(res16), .overflow(ov16)
  );

  logic [16:0] sres [3];
  logic        sdone[3];
  logic        sov  [3];
  int          sw   [3] = '{2, 8, 16};
  assign sres[0] = 17'(res2);
  assign sres[1] = 17'(res8);
  assign sres[2] = res16;
  assign sdone[0] = done2;
  assign sdone[1] = done8;
  assign sdone[2] = done16;
  assign sov[0] = ov2;
  assign sov[1] = ov8;
  assign sov[2] = ov16;

  // ---------------- reference model (plain integer arithmetic) -------------
  function automatic longint sx(input logic [15:0] v, input int w);
    longint one = 1;
    longint r = longint'(v) & ((one << w) - 1);
    if (r >= (one << (w - 1))) r = r - (one << w);
    return r;
  endfunction

  function automatic longint ref_val(input int w, input bit m, input logic [15:0] av,
                                     input logic [15:0] bv);
    return m ? (sx(av, w) - sx(bv, w)) : -sx(av, w);
  endfunction

  function automatic logic [16:0] ref_bits(input int w, input longint r);
    longint one = 1;
    return 17'(r & ((one << (w + 1)) - 1));
  endfunction

  function automatic bit ref_ov(input int w, input longint r);
    longint one = 1;
    return (r < -(one << (w - 1))) || (r > (one << (w - 1)) - 1);
  endfunction

  // ---------------- WIDTH=4 operation helper -------------------------------
  task automatic run4(input string name, input bit m, input logic [3:0] av, input logic [3:0] bv);
    longint r = ref_val(4, m, 16'(av), 16'(bv));
    int lat = 0;
    start4 = 1'b1; mode4 = m; a4 = av; b4 = bv;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = ~av; b4 = ~bv; mode4 = ~m;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (done4) lat = n;
    end
    tests_run++;
    if (lat !== 5) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d want 5", name, lat);
    end
    tests_run++;
    if (res4 !== 5'(ref_bits(4, r)) || ov4 !== ref_ov(4, r)) begin
      tests_failed++;
      $display("FAIL %s result: got %b ov=%b want %b ov=%b", name, res4, ov4,
               5'(ref_bits(4, r)), ref_ov(4, r));
    end
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    rst4 = 1'b0; rsts = 1'b0; start4 = 1'b0; starts = 1'b0;
    mode4 = 1'b0; a4 = '0; b4 = '0; modes = 1'b0; as = '0; bs = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({busy4, done4, res4, ov4} !== 8'b0) begin
      tests_failed++;
      $display("FAIL reset_w4: got busy=%b done=%b res=%b ov=%b want all 0", busy4, done4, res4, ov4);
    end
    tests_run++;
    if ({busy16, done16, res16, ov16} !== 20'b0) begin
      tests_failed++;
      $display("FAIL reset_w16: got busy=%b done=%b res=%h ov=%b want all 0", busy16, done16, res16, ov16);
    end
    rst4 = 1'b1; rsts = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run4("neg_3", 1'b0, 4'b0011, 4'b0101);
    tests_run++;
    if (res4 !== 5'b11101 || ov4 !== 1'b0) begin
      tests_failed++;
      $display("FAIL neg_3_const: got %b ov=%b want 11101 ov=0", res4, ov4);
    end
  endtask

  task automatic test_negate_corner();
    run4("neg_min", 1'b0, 4'b1000, 4'b0000);
    tests_run++;
    if (res4 !== 5'b01000 || ov4 !== 1'b1) begin
      tests_failed++;
      $display("FAIL neg_min_const: got %b ov=%b want 01000 ov=1", res4, ov4);
    end
    run4("neg_zero", 1'b0, 4'b0000, 4'b1111);
  endtask

  task automatic test_subtract();
    run4("sub_7_m8", 1'b1, 4'd7, 4'b1000);
    run4("sub_m8_7", 1'b1, 4'b1000, 4'd7);
    run4("sub_5_3", 1'b1, 4'd5, 4'd3);
    tests_run++;
    if (res4 !== 5'b00010 || ov4 !== 1'b0) begin
      tests_failed++;
      $display("FAIL sub_5_3_const: got %b ov=%b want 00010 ov=0", res4, ov4);
    end
    for (int i = 0; i < 6; i++)
      run4("sub_rand", 1'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic test_ignore_start();
    longint r = ref_val(4, 1'b1, 16'd2, 16'hFFFD);
    int dones = 0;
    int lat = 0;
    start4 = 1'b1; mode4 = 1'b1; a4 = 4'd2; b4 = 4'b1101;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      if (n == 2) begin start4 = 1'b1; mode4 = 1'b0; a4 = 4'd6; b4 = 4'd1; end
      if (n == 3) start4 = 1'b0;
      @(posedge clk); #1;
      if (done4) begin dones++; if (lat == 0) lat = n; end
    end
    tests_run++;
    if (dones !== 1 || lat !== 5) begin
      tests_failed++;
      $display("FAIL ignore_start: got %0d done pulses first at %0d want 1 at 5", dones, lat);
    end
    tests_run++;
    if (res4 !== 5'(ref_bits(4, r)) || ov4 !== ref_ov(4, r)) begin
      tests_failed++;
      $display("FAIL ignore_start_result: got %b ov=%b want %b", res4, ov4, 5'(ref_bits(4, r)));
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] qa[5], qb[5];
    bit         qm[5];
    logic [4:0] prev = res4;
    for (int j = 0; j < 5; j++) begin
      qa[j] = 4'($urandom); qb[j] = 4'($urandom); qm[j] = 1'($urandom);
    end
    start4 = 1'b1; mode4 = qm[0]; a4 = qa[0]; b4 = qb[0];
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) begin
      longint r = ref_val(4, qm[j], 16'(qa[j]), 16'(qb[j]));
      mode4 = qm[j+1]; a4 = qa[j+1]; b4 = qb[j+1];
      for (int c = 1; c <= 6; c++) begin
        @(posedge clk); #1;
        if (c < 5) begin
          tests_run++;
          if (done4 !== 1'b0 || busy4 !== 1'b1 || res4 !== prev) begin
            tests_failed++;
            $display("FAIL b2b_hold op%0d c%0d: got done=%b busy=%b res=%b want 0 1 %b",
                     j, c, done4, busy4, res4, prev);
          end
        end else if (c == 5) begin
          tests_run++;
          if (done4 !== 1'b1 || res4 !== 5'(ref_bits(4, r)) || ov4 !== ref_ov(4, r)) begin
            tests_failed++;
            $display("FAIL b2b_done op%0d: got done=%b res=%b ov=%b want 1 %b %b",
                     j, done4, res4, ov4, 5'(ref_bits(4, r)), ref_ov(4, r));
          end
          prev = 5'(ref_bits(4, r));
          if (j == 3) start4 = 1'b0;
        end else begin
          tests_run++;
          if (done4 !== 1'b0 || busy4 !== (j != 3)) begin
            tests_failed++;
            $display("FAIL b2b_restart op%0d: got done=%b busy=%b want 0 %b", j, done4, busy4, j != 3);
          end
        end
      end
    end
    start4 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    start4 = 1'b1; mode4 = 1'b1; a4 = 4'd3; b4 = 4'd6;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({busy4, done4, res4, ov4} !== 8'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: got busy=%b done=%b res=%b ov=%b want all 0", busy4, done4, res4, ov4);
    end
    rst4 = 1'b1; start4 = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (done4 || busy4) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid_quiet: got %0d active cycles want 0", dones);
    end
    run4("after_reset", 1'b1, 4'd3, 4'd6);
  endtask

  task automatic test_sweep();
    for (int it = 0; it < 30; it++) begin
      longint r[3];
      int     lat[3];
      bit     m = 1'($urandom);
      logic [15:0] av = 16'($urandom);
      logic [15:0] bv = 16'($urandom);
      for (int i = 0; i < 3; i++) begin
        r[i] = ref_val(sw[i], m, av, bv);
        lat[i] = 0;
      end
      starts = 1'b1; modes = m; as = av; bs = bv;
      @(posedge clk); #1;
      starts = 1'b0; as = $urandom; bs = $urandom; modes = ~m;
      for (int n = 1; n <= 20; n++) begin
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
          if (sdone[i] && lat[i] == 0) begin
            lat[i] = n;
            tests_run++;
            if (sres[i] !== ref_bits(sw[i], r[i]) || sov[i] !== ref_ov(sw[i], r[i])) begin
              tests_failed++;
              $display("FAIL sweep_w%0d m=%0d a=%h b=%h: got %h ov=%b want %h ov=%b", sw[i], m,
                       av, bv, sres[i], sov[i], ref_bits(sw[i], r[i]), ref_ov(sw[i], r[i]));
            end
          end
        end
      end
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (lat[i] !== sw[i] + 1) begin
          tests_failed++;
          $display("FAIL sweep_lat_w%0d: got %0d want %0d", sw[i], lat[i], sw[i] + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negate_corner();
    test_subtract();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
